// File: rtl/dvi_pkg.sv
// Shared definitions for the DVI receive path: TMDS control tokens,
// token decoding and the channel aligner state encoding.
package dvi_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctrl;
    } ctrl_decode_t;

    function automatic ctrl_decode_t tmds_ctrl_decode(input logic [9:0] word);
        ctrl_decode_t r;
        r.valid = 1'b1;
        r.ctrl  = 2'b00;
        case (word)
            CTRL_TOKEN_00: r.ctrl = 2'b00;
            CTRL_TOKEN_01: r.ctrl = 2'b01;
            CTRL_TOKEN_10: r.ctrl = 2'b10;
            CTRL_TOKEN_11: r.ctrl = 2'b11;
            default:       r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_decode.sv
// Registered TMDS 10b->8b decoder with control-token detection.
// Control bits are held from the last token through data periods.
module tmds_decode
    import dvi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] word,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl
);

    ctrl_decode_t tok;
    logic [7:0]   d;
    logic [7:0]   x;
    logic [7:0]   dec;

    always_comb begin
        tok = tmds_ctrl_decode(word);
        d   = word[9] ? ~word[7:0] : word[7:0];
        // x[i] = d[i] ^ d[i-1]; bit 0 passes d[0] through unchanged
        x   = d ^ {d[6:0], 1'b0};
        dec = word[8] ? x : {~x[7:1], x[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de   <= 1'b0;
            data <= '0;
            ctrl <= '0;
        end else if (tok.valid) begin
            de   <= 1'b0;
            data <= '0;
            ctrl <= tok.ctrl;
        end else begin
            de   <= 1'b1;
            data <= dec;
        end
    end

endmodule

// File: rtl/dvi_rx_channel.sv
// One TMDS receive channel: input register, word-alignment FSM steering
// IDES10 bitslip, and the registered data/control decoder.
module dvi_rx_channel
    import dvi_pkg::*;
#(
    parameter int unsigned SEARCH_WINDOW = 4096,
    parameter int unsigned LOCK_RUN      = 16,
    parameter int unsigned SLIP_SETTLE   = 8
) (
    input  logic       I_rgb_clk,
    input  logic       I_rst,
    input  logic [9:0] I_word,
    output logic       O_bitslip,
    output logic       O_locked,
    output logic       O_de,
    output logic [7:0] O_data,
    output logic [1:0] O_ctrl,
    output logic [3:0] O_slip_cnt
);

    localparam int unsigned WIN_W = $clog2(SEARCH_WINDOW);
    localparam int unsigned RUN_W = $clog2(LOCK_RUN + 1);
    localparam int unsigned SET_W = $clog2(SLIP_SETTLE + 1);

    localparam logic [WIN_W-1:0] WIN_MAX  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_RUN);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);

    logic [9:0]       word_q;
    logic             word_vld;
    rx_state_t        state, state_n;
    logic [RUN_W-1:0] run_cnt, run_n, run_step;
    logic [1:0]       last_ctrl, last_n;
    logic [WIN_W-1:0] win_cnt, win_n, win_step;
    logic [SET_W-1:0] settle_cnt, settle_n;
    logic [3:0]       slip_cnt, slip_n;
    logic             bitslip_q, bitslip_n;
    logic             locked_q;

    ctrl_decode_t     tok;
    logic             is_tok;
    logic             is_data;
    logic             run_done;
    logic             win_expire;

    always_comb begin
        tok      = tmds_ctrl_decode(word_q);
        is_tok   = word_vld && tok.valid;
        is_data  = word_vld && !tok.valid;
        if ((run_cnt != '0) && (tok.ctrl == last_ctrl))
            run_step = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
        else
            run_step = RUN_W'(1);
        run_done   = is_tok && (run_step == RUN_MAX);
        win_step   = (win_cnt == WIN_MAX) ? win_cnt : win_cnt + WIN_W'(1);
        win_expire = is_data && (win_cnt == WIN_MAX);
    end

    always_comb begin
        state_n   = state;
        run_n     = run_cnt;
        last_n    = last_ctrl;
        win_n     = win_cnt;
        settle_n  = '0;
        slip_n    = slip_cnt;
        bitslip_n = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (is_tok) begin
                    run_n  = run_step;
                    last_n = tok.ctrl;
                    win_n  = '0;
                end else if (is_data) begin
                    run_n  = '0;
                    win_n  = win_step;
                end
                // A completed run takes priority over a coincident window expiry
                if (run_done) begin
                    state_n = ST_LOCKED;
                    run_n   = '0;
                    win_n   = '0;
                end else if (win_expire) begin
                    state_n   = ST_SETTLE;
                    bitslip_n = 1'b1;
                    slip_n    = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
                end
            end
            ST_SETTLE: begin
                run_n    = '0;
                win_n    = '0;
                settle_n = settle_cnt + SET_W'(1);
                if (settle_cnt == SET_LAST) begin
                    state_n  = ST_SEARCH;
                    settle_n = '0;
                end
            end
            ST_LOCKED: begin
                slip_n = '0;
                run_n  = '0;
                if (is_tok) begin
                    win_n = '0;
                end else if (is_data) begin
                    win_n = win_step;
                end
                // Start the fresh search with a cleared window so no slip fires at once
                if (win_expire) begin
                    state_n = ST_SEARCH;
                    win_n   = '0;
                end
            end
            default: state_n = ST_SEARCH;
        endcase
    end

    always_ff @(posedge I_rgb_clk) begin
        if (I_rst) begin
            word_q     <= CTRL_TOKEN_00;
            word_vld   <= 1'b0;
            state      <= ST_SEARCH;
            run_cnt    <= '0;
            last_ctrl  <= '0;
            win_cnt    <= '0;
            settle_cnt <= '0;
            slip_cnt   <= '0;
            bitslip_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            word_q     <= I_word;
            word_vld   <= 1'b1;
            state      <= state_n;
            run_cnt    <= run_n;
            last_ctrl  <= last_n;
            win_cnt    <= win_n;
            settle_cnt <= settle_n;
            slip_cnt   <= slip_n;
            bitslip_q  <= bitslip_n;
            locked_q   <= (state == ST_LOCKED);
        end
    end

    tmds_decode u_decode (
        .clk  (I_rgb_clk),
        .rst  (I_rst),
        .word (word_q),
        .de   (O_de),
        .data (O_data),
        .ctrl (O_ctrl)
    );

    assign O_bitslip  = bitslip_q;
    assign O_locked   = locked_q;
    assign O_slip_cnt = slip_cnt;

endmodule

// File: tb/tb_dvi_rx_channel.sv
// Self-checking bench for dvi_rx_channel: scoreboard of decoded words plus
// alignment, bitslip and lock behaviour against a behavioural stream model.
module tb_dvi_rx_channel;

    localparam int WIN    = 4096;
    localparam int RUN    = 16;
    localparam int SETTLE = 8;

    logic       I_rgb_clk = 1'b0;
    logic       I_rst = 1'b1;
    logic [9:0] I_word = 10'h000;
    logic       O_bitslip;
    logic       O_locked;
    logic       O_de;
    logic [7:0] O_data;
    logic [1:0] O_ctrl;
    logic [3:0] O_slip_cnt;

    dvi_rx_channel #(
        .SEARCH_WINDOW (WIN),
        .LOCK_RUN      (RUN),
        .SLIP_SETTLE   (SETTLE)
    ) dut (
        .I_rgb_clk  (I_rgb_clk),
        .I_rst      (I_rst),
        .I_word     (I_word),
        .O_bitslip  (O_bitslip),
        .O_locked   (O_locked),
        .O_de       (O_de),
        .O_data     (O_data),
        .O_ctrl     (O_ctrl),
        .O_slip_cnt (O_slip_cnt)
    );

    always #5 I_rgb_clk = ~I_rgb_clk;

    typedef struct {
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         nchecks = 0;
    int         nerrors = 0;
    logic [1:0] model_ctrl = 2'b00;
    bit         slip_allowed = 0;
    int         pulses = 0;
    int         rot_m = 0;
    int         last_slip = -1;
    logic       prev_bitslip = 1'b0;
    logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    always @(posedge I_rgb_clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int tok_index(input logic [9:0] w);
        for (int i = 0; i < 4; i++)
            if (w == tok_tab[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] data_decode(input logic [9:0] q);
        logic [7:0] d, o;
        d = q[9] ? ~q[7:0] : q[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++)
            o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    function automatic logic [9:0] ror(input logic [9:0] w, input int r);
        logic [19:0] t;
        t = {w, w};
        t = t >> r;
        return t[9:0];
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023)); while (tok_index(w) >= 0);
        return w;
    endfunction

    // Data words that cannot look like a token under any misalignment
    function automatic logic [9:0] rand_data_safe();
        logic [9:0] w;
        bit ok;
        do begin
            w  = 10'($urandom_range(0, 1023));
            ok = 1;
            for (int r = 0; r < 10; r++)
                if (tok_index(ror(w, r)) >= 0) ok = 0;
        end while (!ok);
        return w;
    endfunction

    task automatic put(input logic [9:0] w);
        exp_t e;
        int   t;
        I_word = w;
        t = tok_index(w);
        if (t >= 0) begin
            model_ctrl = 2'(t);
            e.de   = 1'b0;
            e.data = 8'h00;
        end else begin
            e.de   = 1'b1;
            e.data = data_decode(w);
        end
        e.ctrl = model_ctrl;
        e.due  = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [9:0] w);
        @(posedge I_rgb_clk);
        #1;
        put(w);
    endtask

    task automatic do_reset(input int n);
        @(posedge I_rgb_clk);
        #1;
        I_rst = 1'b1;
        exp_q.delete();
        I_word = 10'($urandom_range(0, 1023));
        for (int i = 0; i < n; i++) begin
            @(posedge I_rgb_clk);
            #1;
            check("reset_outputs", {O_bitslip, O_locked, O_de, O_data, O_ctrl, O_slip_cnt}, 0);
            I_word = 10'($urandom_range(0, 1023));
        end
        I_rst      = 1'b0;
        model_ctrl = 2'b00;
        last_slip  = -1;
        put(10'h1F0);
    endtask

    always @(posedge I_rgb_clk) begin
        #1;
        if (!slip_allowed) begin
            check("no_bitslip", O_bitslip, 0);
        end else if (O_bitslip) begin
            check("bitslip_width", prev_bitslip, 0);
            if (last_slip >= 0)
                check("bitslip_spacing_ok", (cyc - last_slip >= WIN + SETTLE) ? 1 : 0, 1);
            last_slip = cyc;
            pulses++;
            rot_m = (rot_m + 9) % 10;
            check("slip_cnt_on_pulse", O_slip_cnt, pulses % 10);
        end
        prev_bitslip = O_bitslip;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            check("decode", {O_de, O_data, O_ctrl}, {mon_e.de, mon_e.data, mon_e.ctrl});
        end
    end

    initial begin
        #(600000 * 10);
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        nerrors++;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        int p;
        logic [9:0] w;

        do_reset(3);

        // Aligned blanking: lock two cycles after the 16th token is sampled
        for (int i = 0; i < 20; i++) begin
            drive(10'h354);
            if (i == 17) check("lock_not_early", O_locked, 0);
            if (i == 18) check("lock_latency", O_locked, 1);
            if (i == 19) check("slip_cnt_aligned", O_slip_cnt, 0);
        end

        drive(10'h0AB);
        drive(10'h100);
        drive(10'h2FF);
        drive(10'h0AB);
        drive(10'h154);
        drive(10'h2AB);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 30) drive(tok_tab[$urandom_range(0, 3)]);
            else drive(rand_data());
        end
        check("locked_in_mix", O_locked, 1);

        // Unlock after a full window of data words, with no bitslip
        drive(10'h354);
        for (int j = 1; j <= WIN + 100; j++) begin
            drive(rand_data());
            if (j == WIN + 2) check("unlock_not_early", O_locked, 1);
            if (j == WIN + 3) check("unlock_latency", O_locked, 0);
        end

        do_reset(3);

        // Misaligned stream: three slips bring it into alignment
        rot_m  = 3;
        pulses = 0;
        slip_allowed = 1;
        p = 0;
        while (p < 30000 && !O_locked) begin
            w = ((p % 1064) < 64) ? 10'h354 : rand_data_safe();
            drive(ror(w, rot_m));
            p++;
        end
        check("rot_locked", O_locked, 1);
        check("rot_pulses", pulses, 3);
        check("slip_cnt_after_lock", O_slip_cnt, 0);
        for (int i = 0; i < 200; i++) begin
            w = (((p + i) % 1064) < 64) ? 10'h354 : rand_data_safe();
            drive(ror(w, rot_m));
        end
        check("rot_pulses_stable", pulses, 3);
        check("rot_still_locked", O_locked, 1);
        slip_allowed = 0;

        // Reset straddling the cycle in which a bitslip would be issued
        do_reset(3);
        for (int i = 0; i < WIN - 3; i++) drive(rand_data());
        do_reset(6);
        for (int i = 0; i < 10; i++) drive(rand_data());
        check("locked_after_reset", O_locked, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
